// File: rtl/conv_layer_sequencer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : conv_layer_sequencer_pkg
// Brief  : Shared types and helpers for the convolutional layer sequencer.
//          Holds the frame-control state encoding and the counter width helper.
// Rev    : 1.0  initial release
// ============================================================================
package conv_layer_sequencer_pkg;

    // Frame-control states: IDLE=0, RUN=1, DRAIN=2
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    // Width of a counter that indexes 0 .. n-1 (at least one bit)
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_layer_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : conv_layer_sequencer_if
// Brief  : Pixel input stream and result output stream of the sequencer.
//          master = image source / result sink side, slave = sequencer side.
// Rev    : 1.0  initial release
// ============================================================================
interface conv_layer_sequencer_if #(
    parameter int D_BITS = 8,
    parameter int Q_BITS = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [D_BITS-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [Q_BITS-1:0] out_data;
    logic              out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/conv_layer_sequencer_out_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : conv_seq_out_stage
// Brief  : Result capture for the sequencer: one-cycle pending flag, optional
//          per-lane ReLU, output register with valid/last hold, sticky error
//          when the layer does not flag valid in the pending cycle.
//          Optional feature macro: CONV_SEQ_RELU_EN (clamp negative lanes to 0).
// Rev    : 1.0  initial release
// ============================================================================
module conv_seq_out_stage #(
    parameter int Q_WIDTH    = 16,
    parameter int Q_CHANNELS = 1
) (
    input  wire                           clk,
    input  wire                           rst,
    input  wire                           capture,
    input  wire                           capture_last,
    input  wire [Q_WIDTH*Q_CHANNELS-1:0]  conv_q,
    input  wire                           conv_valid,
    input  wire                           out_ready,
    output logic                          pend,
    output logic                          out_valid,
    output logic [Q_WIDTH*Q_CHANNELS-1:0] out_data,
    output logic                          out_last,
    output logic                          err
);

    logic                          pend_last;
    logic [Q_WIDTH*Q_CHANNELS-1:0] q_act;

    for (genvar i = 0; i < Q_CHANNELS; i++) begin : g_lane
`ifdef CONV_SEQ_RELU_EN
        // Signed lane: negative results become zero
        assign q_act[i*Q_WIDTH +: Q_WIDTH] = conv_q[(i+1)*Q_WIDTH-1] ? '0
                                           : conv_q[i*Q_WIDTH +: Q_WIDTH];
`else
        assign q_act[i*Q_WIDTH +: Q_WIDTH] = conv_q[i*Q_WIDTH +: Q_WIDTH];
`endif
    end

    // Pending flag: the layer result for a window pixel is sampled one cycle after accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            pend      <= capture;
            pend_last <= capture_last;
        end
    end

    // Output register: load while pending, otherwise hold until the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (pend) begin
            out_valid <= 1'b1;
            out_data  <= q_act;
            out_last  <= pend_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // Sticky error: layer must report valid exactly when we sample it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (pend && !conv_valid) begin
            err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_layer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : conv_layer_sequencer
// Brief  : Frames one IMAGE_SIZE x IMAGE_SIZE image through a convolutional
//          layer: accepts pixels, pulses the layer enable per pixel, and
//          forwards each valid-window result with a last marker.
//          Optional feature macro: CONV_SEQ_RELU_EN (see conv_seq_out_stage).
// Rev    : 1.0  initial release
// ============================================================================
module conv_layer_sequencer
    import conv_layer_sequencer_pkg::*;
#(
    parameter int D_WIDTH     = 8,
    parameter int Q_WIDTH     = 16,
    parameter int D_CHANNELS  = 1,
    parameter int Q_CHANNELS  = 1,
    parameter int FILTER_SIZE = 3,
    parameter int IMAGE_SIZE  = 28
) (
    input  wire                           clk,
    input  wire                           rst,
    input  wire                           start,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    conv_layer_sequencer_if.slave         strm,
    output logic                          conv_en,
    output logic [D_WIDTH*D_CHANNELS-1:0] conv_d,
    input  wire  [Q_WIDTH*Q_CHANNELS-1:0] conv_q,
    input  wire                           conv_valid
);

    localparam int            CW       = cnt_width(IMAGE_SIZE);
    localparam logic [CW-1:0] LAST_IDX = CW'(IMAGE_SIZE - 1);
    localparam logic [CW-1:0] WIN_MIN  = CW'(FILTER_SIZE - 1);

    seq_state_t                    state;
    logic [CW-1:0]                 row;
    logic [CW-1:0]                 col;
    logic                          pend;
    logic                          out_valid;
    logic                          out_last;
    logic [Q_WIDTH*Q_CHANNELS-1:0] out_data;
    logic                          in_ready;
    logic                          win;
    logic                          last_px;
    logic                          last_hs;

    // A window pixel blocks the next accept for one cycle (pend) and no pixel
    // is taken while an unconsumed result would be overwritten.
    assign in_ready = (state == ST_RUN) && !pend && (!out_valid || strm.out_ready);
    assign conv_en  = strm.in_valid && in_ready;
    assign conv_d   = strm.in_data;
    assign win      = (row >= WIN_MIN) && (col >= WIN_MIN);
    assign last_px  = (row == LAST_IDX) && (col == LAST_IDX);
    assign last_hs  = out_valid && strm.out_ready && out_last;

    assign strm.in_ready  = in_ready;
    assign strm.out_valid = out_valid;
    assign strm.out_data  = out_data;
    assign strm.out_last  = out_last;

    // Pixel position: col inner, row outer; both wrap to 0 at frame end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (conv_en) begin
            if (col == LAST_IDX) begin
                col <= '0;
                row <= (row == LAST_IDX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Frame control: IDLE waits for start, RUN feeds the layer, DRAIN waits for the last result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (conv_en && last_px) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_hs) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    conv_seq_out_stage #(
        .Q_WIDTH    (Q_WIDTH),
        .Q_CHANNELS (Q_CHANNELS)
    ) u_out_stage (
        .clk          (clk),
        .rst          (rst),
        .capture      (conv_en && win),
        .capture_last (conv_en && last_px),
        .conv_q       (conv_q),
        .conv_valid   (conv_valid),
        .out_ready    (strm.out_ready),
        .pend         (pend),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .err          (err)
    );

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_conv_layer_sequencer
// Brief  : Self-checking bench for conv_layer_sequencer (4x4 image, 3x3 window)
//          with a stand-in layer and a frame-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_conv_layer_sequencer;

    localparam int N    = 4;
    localparam int F    = 3;
    localparam int NPIX = N * N;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic        conv_en;
    logic [7:0]  conv_d;
    logic [15:0] conv_q;
    logic        conv_valid;

    conv_layer_sequencer_if #(.D_BITS(8), .Q_BITS(16)) strm ();

    conv_layer_sequencer #(
        .D_WIDTH(8), .Q_WIDTH(16), .D_CHANNELS(1), .Q_CHANNELS(1),
        .FILTER_SIZE(F), .IMAGE_SIZE(N)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .strm(strm), .conv_en(conv_en), .conv_d(conv_d),
        .conv_q(conv_q), .conv_valid(conv_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Stand-in layer result for a pixel, and what the sequencer must emit for it
    function automatic logic [15:0] layer_fn(input logic [7:0] x);
        return {x ^ 8'h5A, x};
    endfunction

    function automatic logic [15:0] expect_out(input logic [7:0] x);
        logic [15:0] v;
        v = layer_fn(x);
`ifdef CONV_SEQ_RELU_EN
        if (v[15]) v = 16'h0000;
`endif
        return v;
    endfunction

    function automatic bit in_window(input int idx);
        return ((idx / N) >= F - 1) && ((idx % N) >= F - 1);
    endfunction

    // Stand-in layer: result and valid registered on each enable
    int          lay_cnt;
    logic [15:0] lay_q;
    logic        lay_v;
    logic        force_bad;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lay_cnt <= 0;
            lay_q   <= '0;
            lay_v   <= 1'b0;
        end else if (conv_en) begin
            lay_q   <= layer_fn(conv_d);
            lay_v   <= in_window(lay_cnt);
            lay_cnt <= (lay_cnt + 1) % NPIX;
        end
    end
    assign conv_q     = lay_q;
    assign conv_valid = lay_v & ~force_bad;

    // Reference model state
    typedef struct {
        logic [15:0] data;
        logic        last;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          m_px = 0;
    bit          m_busy = 0;
    bit          m_err = 0;
    int          done_due = -1;
    bit          win_prev = 0;
    bit          prev_vld = 0;
    bit          prev_hs = 0;
    logic [15:0] prev_data = '0;
    logic        prev_last = 1'b0;
    int          n_results = 0;
    int          n_done = 0;
    logic [15:0] res_log[$];

    // Compare process: every cycle, DUT against the frame-level model
    always @(negedge clk) begin
        bit   acc;
        bit   hs;
        bit   w;
        exp_t e;
        if (rst) begin
            exp_q.delete();
            m_px = 0; m_busy = 0; m_err = 0; done_due = -1;
            win_prev = 0; prev_vld = 0; prev_hs = 0;
            chk("rst_busy",      32'(busy), 32'd0);
            chk("rst_done",      32'(done), 32'd0);
            chk("rst_err",       32'(err), 32'd0);
            chk("rst_in_ready",  32'(strm.in_ready), 32'd0);
            chk("rst_out_valid", 32'(strm.out_valid), 32'd0);
            chk("rst_out_last",  32'(strm.out_last), 32'd0);
            chk("rst_out_data",  32'(strm.out_data), 32'd0);
        end else begin
            acc = strm.in_valid && strm.in_ready;
            hs  = strm.out_valid && strm.out_ready;
            chk("busy",    32'(busy), 32'(m_busy));
            chk("done",    32'(done), 32'(cyc == done_due));
            chk("err",     32'(err), 32'(m_err));
            chk("conv_en", 32'(conv_en), 32'(acc));
            if (acc) chk("conv_d", 32'(conv_d), 32'(strm.in_data));
            if (!m_busy || m_px >= NPIX) chk("in_ready_not_run", 32'(strm.in_ready), 32'd0);
            if (strm.out_valid && !strm.out_ready) chk("in_ready_backpressure", 32'(strm.in_ready), 32'd0);
            if (win_prev) begin
                chk("in_ready_after_window", 32'(strm.in_ready), 32'd0);
                if (!conv_valid) m_err = 1;
            end
            if (prev_vld && !prev_hs) begin
                chk("out_valid_hold", 32'(strm.out_valid), 32'd1);
                chk("out_data_hold",  32'(strm.out_data), 32'(prev_data));
                chk("out_last_hold",  32'(strm.out_last), 32'(prev_last));
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc)
                chk("out_valid_due", 32'(strm.out_valid), 32'd1);
            if (strm.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("out_spurious", 32'd1, 32'd0);
                end else begin
                    if (!prev_vld || prev_hs) chk("out_latency", 32'(cyc), 32'(exp_q[0].due));
                    chk("out_data", 32'(strm.out_data), 32'(exp_q[0].data));
                    chk("out_last", 32'(strm.out_last), 32'(exp_q[0].last));
                end
            end
            if (hs && exp_q.size() > 0) begin
                res_log.push_back(strm.out_data);
                n_results++;
                if (exp_q[0].last) begin
                    done_due = cyc + 1;
                    m_busy = 0;
                end
                void'(exp_q.pop_front());
            end
            if (done) n_done++;
            w = 0;
            if (acc) begin
                w = in_window(m_px);
                if (w) begin
                    e.data = expect_out(strm.in_data);
                    e.last = (m_px == NPIX - 1);
                    e.due  = cyc + 2;
                    exp_q.push_back(e);
                end
                m_px++;
            end
            win_prev = w;
            if (!m_busy && start && !(hs && strm.out_last)) begin
                m_busy = 1;
                m_px = 0;
            end
            prev_vld  = strm.out_valid;
            prev_hs   = hs;
            prev_data = strm.out_data;
            prev_last = strm.out_last;
        end
    end

    // Result-side ready: mode 0 always ready, mode 1 random, mode 2 left to the test
    int ordy_mode = 0;
    always @(posedge clk) begin
        #1;
        if (ordy_mode == 0) strm.out_ready = 1'b1;
        else if (ordy_mode == 1) strm.out_ready = 1'($urandom_range(0, 1));
    end

    // All stimulus tasks begin and end 1 time unit after a rising edge
    task automatic send_pixel(input logic [7:0] d, input bit gaps);
        int t;
        bit ok;
        t = 0;
        ok = 0;
        if (gaps) begin
            strm.in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        strm.in_valid = 1'b1;
        strm.in_data  = d;
        while (!ok && t < 200) begin
            @(negedge clk);
            if (strm.in_ready) ok = 1;
            t++;
        end
        chk("pixel_accept_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        strm.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        bit seen;
        t = 0;
        seen = 0;
        while (!seen && t < 300) begin
            @(negedge clk);
            if (done) seen = 1;
            t++;
        end
        chk("done_timeout", 32'(seen), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic clr_counts();
        n_results = 0;
        n_done = 0;
        res_log.delete();
    endtask

    task automatic frame_counts(input string tag);
        chk({tag, "_results"}, 32'(n_results), 32'd4);
        chk({tag, "_done_pulses"}, 32'(n_done), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [15:0] t1_exp [4];
    logic [15:0] stall_data;
    logic [7:0]  px;

    initial begin
        t1_exp[0] = 16'h401A; t1_exp[1] = 16'h411B; t1_exp[2] = 16'h441E; t1_exp[3] = 16'h451F;
        rst = 1'b1; start = 1'b0; force_bad = 1'b0;
        strm.in_valid = 1'b0; strm.in_data = '0; strm.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Pixels offered before start are not taken
        strm.in_valid = 1'b1; strm.in_data = 8'h77;
        repeat (3) begin @(posedge clk); #1; end
        strm.in_valid = 1'b0;

        // 1: back-to-back frame, fixed data; input held valid during drain
        clr_counts();
        pulse_start();
        for (int i = 0; i < NPIX; i++) send_pixel(8'(8'h10 + i), 1'b0);
        strm.in_valid = 1'b1; strm.in_data = 8'h99;
        wait_done();
        strm.in_valid = 1'b0;
        frame_counts("t1");
        chk("t1_log_size", 32'(res_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < res_log.size(); i++) chk("t1_literal", 32'(res_log[i]), 32'(t1_exp[i]));

        // 2: output stalled for 10 cycles from the first result
        clr_counts();
        ordy_mode = 2;
        strm.out_ready = 1'b0;
        pulse_start();
        fork
            begin
                for (int i = 0; i < NPIX; i++) send_pixel(8'($urandom), 1'b0);
            end
            begin
                int t;
                t = 0;
                while (!strm.out_valid && t < 200) begin @(negedge clk); t++; end
                chk("t2_first_result", 32'(strm.out_valid), 32'd1);
                stall_data = strm.out_data;
                repeat (10) begin
                    @(negedge clk);
                    chk("t2_stall_in_ready", 32'(strm.in_ready), 32'd0);
                    chk("t2_stall_data", 32'(strm.out_data), 32'(stall_data));
                end
                @(posedge clk); #1;
                ordy_mode = 0;
                strm.out_ready = 1'b1;
            end
        join
        wait_done();
        frame_counts("t2");

        // 3: start pulsed mid-frame is ignored
        clr_counts();
        pulse_start();
        for (int i = 0; i < NPIX; i++) begin
            if (i == 5) start = 1'b1;
            send_pixel(8'($urandom), 1'b0);
            start = 1'b0;
        end
        wait_done();
        repeat (5) begin @(posedge clk); #1; end
        frame_counts("t3");

        // 4: reset after pixel 7, then a full frame
        pulse_start();
        for (int i = 0; i < 8; i++) send_pixel(8'($urandom), 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t4_busy_async", 32'(busy), 32'd0);
        chk("t4_out_valid_async", 32'(strm.out_valid), 32'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        clr_counts();
        pulse_start();
        for (int i = 0; i < NPIX; i++) send_pixel(8'($urandom), 1'b0);
        wait_done();
        frame_counts("t4");

        // 5: layer reports invalid at capture; error sticky until reset
        clr_counts();
        force_bad = 1'b1;
        pulse_start();
        for (int i = 0; i < NPIX; i++) send_pixel(8'($urandom), 1'b0);
        wait_done();
        force_bad = 1'b0;
        chk("t5_err_set", 32'(err), 32'd1);
        clr_counts();
        pulse_start();
        for (int i = 0; i < NPIX; i++) send_pixel(8'($urandom), 1'b1);
        wait_done();
        chk("t5_err_sticky", 32'(err), 32'd1);
        do_reset();
        chk("t5_err_cleared", 32'(err), 32'd0);

        // 6: sign handling of the result lanes
        clr_counts();
        pulse_start();
        for (int i = 0; i < NPIX; i++) begin
            px = 8'($urandom);
            if (i == 10) px = 8'hAA;
            if (i == 11) px = 8'h48;
            send_pixel(px, 1'b0);
        end
        wait_done();
        frame_counts("t6");
        if (res_log.size() >= 2) begin
`ifdef CONV_SEQ_RELU_EN
            chk("t6_negative_lane", 32'(res_log[0]), 32'h0000);
`else
            chk("t6_negative_lane", 32'(res_log[0]), 32'hF0AA);
`endif
            chk("t6_positive_lane", 32'(res_log[1]), 32'h1248);
        end else begin
            chk("t6_log_size", 32'(res_log.size()), 32'd4);
        end

        // 7: random data, random input gaps, random output backpressure
        ordy_mode = 1;
        for (int k = 0; k < 6; k++) begin
            clr_counts();
            pulse_start();
            for (int i = 0; i < NPIX; i++) send_pixel(8'($urandom), 1'b1);
            wait_done();
            frame_counts("t7");
        end
        ordy_mode = 0;
        repeat (3) begin @(posedge clk); #1; end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
